// File: rtl/nios2cpu_copy_pkg.sv
// Shared types and constants for the Nios II RAM-to-RAM copy master.
package nios2cpu_copy_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int LEN_W_DEF  = 14;
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   fifo_full;
        logic   fifo_empty;
    } dbg_t;

endpackage

// File: rtl/nios2cpu_sync_fifo.sv
// Single-clock FIFO with a combinational head output; the head only changes on a pop.
module nios2cpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/nios2cpu_ram_copy_master.sv
// Avalon-MM copy engine: a credit-limited read master fills a FIFO that a write master
// drains to the destination region, one 32-bit word per accepted transfer.
module nios2cpu_ram_copy_master
    import nios2cpu_copy_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_read,
    input  logic [31:0]       rd_readdata,
    input  logic              rd_readdatavalid,
    input  logic              rd_waitrequest,
    output logic [ADDR_W-1:0] wr_address,
    output logic              wr_write,
    output logic [31:0]       wr_writedata,
    output logic [3:0]        wr_byteenable,
    input  logic              wr_waitrequest,
    output dbg_t              dbg
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a request (rd_read / wr_write) is accepted on an edge where it is high and
    // waitrequest is low; until then address and data are held. rd_readdatavalid is never
    // stalled, so every issued read must already own a FIFO slot (outstanding + fifo_count).

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rd_issued;
    logic [LEN_W-1:0] wr_count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    logic             rd_acc;
    logic             rd_vld;
    logic             wr_acc;
    logic             last_write;
    logic [LEN_W-1:0] issued_nx;
    logic [CNT_W-1:0] outstanding_nx;
    logic [CNT_W-1:0] fifo_count_nx;
    logic [CNT_W:0]   credit_nx;

    assign rd_acc     = rd_read && !rd_waitrequest;
    assign rd_vld     = rd_readdatavalid && (state == ST_RUN);
    assign wr_acc     = wr_write && !wr_waitrequest;
    assign last_write = wr_acc && ((wr_count + LEN_W'(1)) == len_q);

    always_comb begin
        issued_nx      = rd_issued + LEN_W'(rd_acc);
        outstanding_nx = outstanding + CNT_W'(rd_acc) - CNT_W'(rd_vld);
        fifo_count_nx  = fifo_count + CNT_W'(rd_vld) - CNT_W'(wr_acc);
        credit_nx      = {1'b0, outstanding_nx} + {1'b0, fifo_count_nx};
    end

    nios2cpu_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_vld),
        .push_data (rd_readdata),
        .pop       (wr_acc),
        .head      (wr_writedata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_byteenable = BYTEEN_ALL;
    assign dbg           = '{state: state, fifo_full: fifo_full, fifo_empty: fifo_empty};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_read     <= 1'b0;
            wr_write    <= 1'b0;
            rd_address  <= '0;
            wr_address  <= '0;
            len_q       <= '0;
            rd_issued   <= '0;
            wr_count    <= '0;
            outstanding <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q       <= len;
                        rd_issued   <= '0;
                        wr_count    <= '0;
                        outstanding <= '0;
                        rd_address  <= src_addr;
                        wr_address  <= dst_addr;
                        busy        <= 1'b1;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            rd_read <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    rd_issued   <= issued_nx;
                    outstanding <= outstanding_nx;
                    if (rd_acc) begin
                        rd_address <= rd_address + ADDR_W'(1);
                    end
                    if (wr_acc) begin
                        wr_address <= wr_address + ADDR_W'(1);
                        wr_count   <= wr_count + LEN_W'(1);
                    end
                    if (last_write) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        rd_read  <= 1'b0;
                        wr_write <= 1'b0;
                    end else begin
                        rd_read  <= (issued_nx < len_q) &&
                                    (credit_nx < (CNT_W + 1)'(FIFO_DEPTH));
                        wr_write <= (fifo_count_nx != '0);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2cpu_ram_copy_master.sv
// Directed bench for the copy master: bus slave models, expected-write scoreboard, summary.
module tb_nios2cpu_ram_copy_master;
    import nios2cpu_copy_pkg::*;

    localparam int ADDR_W = 13;
    localparam int LEN_W  = 14;
    localparam int DEPTH  = 8;
    localparam int SB_W   = ADDR_W + 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_read;
    logic [31:0]       rd_readdata = '0;
    logic              rd_readdatavalid = 1'b0;
    logic              rd_waitrequest = 1'b0;
    logic [ADDR_W-1:0] wr_address;
    logic              wr_write;
    logic [31:0]       wr_writedata;
    logic [3:0]        wr_byteenable;
    logic              wr_waitrequest = 1'b0;
    dbg_t              dbg;

    nios2cpu_ram_copy_master #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .len              (len),
        .busy             (busy),
        .done             (done),
        .rd_address       (rd_address),
        .rd_read          (rd_read),
        .rd_readdata      (rd_readdata),
        .rd_readdatavalid (rd_readdatavalid),
        .rd_waitrequest   (rd_waitrequest),
        .wr_address       (wr_address),
        .wr_write         (wr_write),
        .wr_writedata     (wr_writedata),
        .wr_byteenable    (wr_byteenable),
        .wr_waitrequest   (wr_waitrequest),
        .dbg              (dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a);
        return 32'hA5A5_0000 + {19'b0, a} * 32'd3;
    endfunction

    // ---------------- bus models and scoreboard ----------------
    logic [SB_W-1:0]   exp_q[$];
    logic [31:0]       rsp_q[$];
    int                rsp_dly[$];
    logic [ADDR_W-1:0] rd_log[$];
    logic [31:0]       dst_mem [8192];

    int rd_wait_pct = 0;
    int wr_wait_pct = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit wr_hold = 0;
    bit force_wait = 0;
    bit credit_en = 1;
    int rd_acc_cnt = 0;
    int wr_acc_cnt = 0;
    int rsp_returned = 0;
    int credit_viol = 0;
    int act_cnt = 0;

    always @(negedge clk) begin
        logic [SB_W-1:0] sb;
        rd_readdatavalid = 1'b0;
        if (rsp_q.size() > 0 && rsp_dly[0] == 0) begin
            rd_readdatavalid = 1'b1;
            rd_readdata = rsp_q.pop_front();
            void'(rsp_dly.pop_front());
            rsp_returned++;
        end
        foreach (rsp_dly[i]) if (rsp_dly[i] > 0) rsp_dly[i] = rsp_dly[i] - 1;

        rd_waitrequest = force_wait || (int'($urandom_range(99)) < rd_wait_pct);
        if (rd_read && !rd_waitrequest) begin
            rsp_q.push_back(pat(rd_address));
            rsp_dly.push_back(int'($urandom_range(lat_max, lat_min)) - 1);
            rd_log.push_back(rd_address);
            rd_acc_cnt++;
        end

        wr_waitrequest = force_wait || wr_hold || (int'($urandom_range(99)) < wr_wait_pct);
        if (wr_write && !wr_waitrequest) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {51'b0, wr_address}, 64'hFFFF);
            end else begin
                sb = exp_q.pop_front();
                check("wr_addr", {51'b0, wr_address}, {51'b0, sb[SB_W-1:32]});
                check("wr_data", {32'b0, wr_writedata}, {32'b0, sb[31:0]});
            end
            dst_mem[wr_address] = wr_writedata;
            wr_acc_cnt++;
        end

        if (rd_read || wr_write) act_cnt++;
        if (credit_en && (rsp_q.size() + rsp_returned - wr_acc_cnt) > DEPTH) credit_viol++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_bus(input int rw, input int ww, input int lmin, input int lmax);
        rd_wait_pct = rw;
        wr_wait_pct = ww;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [LEN_W-1:0] n);
        logic [ADDR_W-1:0] wa;
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < int'(n); i++) begin
            wa = d + ADDR_W'(i);
            ra = s + ADDR_W'(i);
            exp_q.push_back({wa, pat(ra)});
        end
        rd_log.delete();
        rd_acc_cnt = 0;
        wr_acc_cnt = 0;
        rsp_returned = 0;
        credit_viol = 0;
        @(posedge clk); #1;
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        len = n;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", {63'b0, busy}, 64'd1);
        check("start_rd_read", {63'b0, rd_read}, {63'b0, (n != '0)});
    endtask

    task automatic finish_wait(input int budget, input string tag);
        int i = 0;
        int extra = 0;
        while (!done && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check({tag, "_done_seen"}, {63'b0, done}, 64'd1);
        @(posedge clk); #1;
        check({tag, "_done_low"}, {63'b0, done}, 64'd0);
        check({tag, "_busy_low"}, {63'b0, busy}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check({tag, "_extra_done"}, 64'(extra), 64'd0);
        check({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_credit"}, 64'(credit_viol), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        int i;
        for (int a = 0; a < 8192; a++) dst_mem[a] = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_rd_read", {63'b0, rd_read}, 64'd0);
        check("rst_wr_write", {63'b0, wr_write}, 64'd0);
        check("rst_rd_addr", {51'b0, rd_address}, 64'd0);
        check("rst_wr_addr", {51'b0, wr_address}, 64'd0);
        check("byteenable", {60'b0, wr_byteenable}, 64'hF);
        reset_n = 1'b1;

        // basic 4-word copy, no stalls, latency 1
        set_bus(0, 0, 1, 1);
        kick(13'h0010, 13'h0100, 14'd4);
        finish_wait(200, "t1");
        for (int k = 0; k < 4; k++)
            check("t1_ram", {32'b0, dst_mem[13'h0100 + k]}, {32'b0, pat(13'h0010 + 13'(k))});

        // zero-length start: done only, no bus activity
        act_cnt = 0;
        kick(13'h0020, 13'h0200, 14'd0);
        check("t2_done_now", {63'b0, done}, 64'd1);
        finish_wait(5, "t2");
        check("t2_no_bus", 64'(act_cnt), 64'd0);

        // writes stalled: reads must stop at the FIFO credit
        wr_hold = 1;
        kick(13'h0400, 13'h0600, 14'd20);
        repeat (30) begin @(posedge clk); #1; end
        check("t3_reads_held", 64'(rd_acc_cnt), 64'd8);
        check("t3_no_writes", 64'(wr_acc_cnt), 64'd0);
        wr_hold = 0;
        finish_wait(500, "t3");
        check("t3_writes", 64'(wr_acc_cnt), 64'd20);

        // address wrap with random stalls on both masters
        set_bus(40, 40, 1, 3);
        kick(13'h1FFE, 13'h1FFF, 14'd3);
        finish_wait(400, "t4");
        check("t4_rd_cnt", 64'(rd_log.size()), 64'd3);
        check("t4_rd0", {51'b0, rd_log[0]}, 64'h1FFE);
        check("t4_rd1", {51'b0, rd_log[1]}, 64'h1FFF);
        check("t4_rd2", {51'b0, rd_log[2]}, 64'h0000);

        // variable latency, long copy, stray start while running
        set_bus(30, 20, 1, 5);
        kick(13'h0200, 13'h0900, 14'd64);
        repeat (10) begin @(posedge clk); #1; end
        start = 1'b1; src_addr = 13'h0000; dst_addr = 13'h0000; len = 14'd5;
        @(posedge clk); #1;
        start = 1'b0;
        finish_wait(3000, "t5");
        check("t5_reads", 64'(rd_acc_cnt), 64'd64);

        // reset mid-transfer with responses still in flight
        set_bus(0, 0, 3, 5);
        kick(13'h0300, 13'h0A00, 14'd16);
        i = 0;
        while (wr_acc_cnt < 5 && i < 300) begin @(posedge clk); #1; i++; end
        check("t6_reached5", 64'(wr_acc_cnt), 64'd5);
        force_wait = 1;
        credit_en = 0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        check("t6_busy", {63'b0, busy}, 64'd0);
        check("t6_done", {63'b0, done}, 64'd0);
        check("t6_rd_read", {63'b0, rd_read}, 64'd0);
        check("t6_wr_write", {63'b0, wr_write}, 64'd0);
        check("t6_rd_addr", {51'b0, rd_address}, 64'd0);
        check("t6_wr_addr", {51'b0, wr_address}, 64'd0);
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy || wr_write || rd_read) bad++;
        end
        check("t6_quiet", 64'(bad), 64'd0);
        check("t6_drained", 64'(rsp_q.size()), 64'd0);
        force_wait = 0;
        credit_en = 1;
        set_bus(0, 0, 1, 1);
        kick(13'h0050, 13'h0C00, 14'd2);
        finish_wait(200, "t6b");
        check("t6b_writes", 64'(wr_acc_cnt), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
